// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// adder_pkg : shared state encoding and slice width for nibble_serial_adder
// Revision  : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_ripple.sv
// ============================================================================
// ripple_Adder : purely combinational 4-bit ripple-carry adder slice
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ripple_Adder
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             Cin,
  output logic             Cout,
  output logic [NIB_W-1:0] S
);

  logic [NIB_W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign S[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign Cout = c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder : WIDTH-bit adder streamed one nibble per clock through
//                       a single 4-bit ripple slice, valid/ready on both sides
// Revision            : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             accept;

  ripple_Adder u_slice (
    .x    (a_q[idx_q*NIB_W +: NIB_W]),
    .y    (b_q[idx_q*NIB_W +: NIB_W]),
    .Cin  (carry_q),
    .Cout (slice_cout),
    .S    (slice_s)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
        // Accepting from DONE gives the zero-bubble back-to-back handoff.
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = slice_s;
        carry_d                     = slice_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIB_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder : directed self-checking bench for nibble_serial_adder
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits at negedges for out_valid, returning the number of clocks taken.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~va;
    b        = va ^ 16'h5A5A;
    cin      = ~vc;
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("mixed",   16'hF9A7, 16'h1B3C, 1'b1, 16'h14E4, 1'b1, 1'b0);

    // Backpressure: hold result in DONE for three clocks.
    a        = 16'hF9A7;
    b        = 16'h1B3C;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'h14E4);
      chk("bp_hold_cout", 32'(cout), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    // Release with a new op waiting: accepted on the same edge.
    a         = 16'h0F0F;
    b         = 16'h00F1;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    chk("b2b_out_valid_low", 32'(out_valid), 32'd0);
    chk("b2b_in_ready_low", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("b2b_latency", 32'(lat), 32'd4);
    chk("b2b_sum", 32'(sum), 32'h1000);
    chk("b2b_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset two clocks into RUN aborts the operation.
    a        = 16'h5555;
    b        = 16'h1111;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
